mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle main control FSM for the MIPS core.
- Sequences instruction fetch, decode, execute, memory access and writeback.
- Drives the 3-bit ALU operation class consumed by the ALU control decoder, plus all datapath mux selects and write strobes.
- Sits between the instruction register (opcode source), the memory port (ready handshake) and the register-file, PC and ALU muxes.

Parameters:
- OPW, 6, opcode width
- STW, 4, state register width (must hold 14 states)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPW  instruction opcode from the IR output; valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  conditional PC load, qualified in the datapath by branch_type and the ALU flags
- branch_type  out  2  00 beq (zero), 01 bne (~zero), 10 bgtz (ALU result>0), 11 unused
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  writeback data select: 1 = MDR
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- reg_write  out  1  register file write
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- pc_source  out  2  PC source: 00 ALU, 01 ALUOut, 10 jump target
- alu_op  out  3  ALU class: 000 add, 001 sub, 010 funct (R-type), 011 imm via opcode[2:0], 100 bgtz
- illegal_op  out  1  illegal opcode flag
- state  out  STW  current state, for debug

Behaviour:
- Reset: rst_n low asynchronously forces state RESET (0). In RESET every output is 0 and state=0. First rising clk with rst_n high moves to FETCH.
- Reset mid-instruction aborts immediately; no strobe may glitch high during reset.
- Outputs are Moore-decoded from state, except ir_write and pc_write in FETCH, which are asserted only when mem_ready=1.
- State encodings: RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, IMMEX 9, IMMWB 10, BRANCH 11, JUMP 12, TRAP 13.
- FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=000, pc_source=00. Stays while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: src_a=0, src_b=11, alu_op=000 (branch target into ALUOut). Dispatch on opcode:
  - 000000 -> EXEC
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000100 / 000101 / 000111 -> BRANCH
  - 000010 -> JUMP
  - 001xxx -> IMMEX
  - anything else -> illegal handling
- MEMADR: src_a=1, src_b=10, alu_op=000. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Waits for mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR: mem_write=1, i_or_d=1. Waits for mem_ready, then FETCH.
- EXEC: src_a=1, src_b=00, alu_op=010. Then ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- IMMEX: src_a=1, src_b=10, alu_op=011. Then IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- BRANCH: src_a=1, src_b=00, pc_write_cond=1, pc_source=01.
  - beq: alu_op=001, branch_type=00
  - bne: alu_op=001, branch_type=01
  - bgtz: alu_op=100, branch_type=10
  - Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- Latency with mem_ready always 1: R-type 4, lw 5, sw 4, imm 4, branch 3, j 3 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Every state not named above holds all outputs at 0.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE moves to TRAP. TRAP holds all strobes at 0 and illegal_op=1 until reset.
- Undefined: an illegal opcode returns DECODE to FETCH (treated as a nop), illegal_op is pulsed for that single DECODE cycle, and the TRAP encoding is unreachable.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state localparams
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BGTZ, OP_J, OP_IMM_PFX)
  - ALUOP_* codes
  - SRCB_* codes
  - PCSRC_* codes
  - BR_* codes
- One sub-module: mc_ctrl_decode, a purely combinational map from state, opcode and mem_ready to the control outputs.
- The state register and next-state logic stay in mc_ctrl_fsm.

Test Plan:
- Reset mid-MEMRD (rst_n low asynchronously) -> state=0 and all outputs 0 before the next edge; FETCH on the first edge after release.
- opcode=000000, mem_ready=1 -> states 1,2,7,8,1; alu_op=010 in EXEC; reg_write=1 with reg_dst=1 in ALUWB.
- lw (100011) with mem_ready low for 2 cycles in MEMRD -> MEMRD held 3 cycles; MEMWB has mem_to_reg=1; total 7 cycles.
- bgtz (000111) -> BRANCH with alu_op=100, branch_type=10, pc_write_cond=1, pc_source=01; bne (000101) -> alu_op=001, branch_type=01.
- addi (001000) -> IMMEX with alu_op=011, src_b=10; IMMWB with reg_dst=0.
- opcode=111111 -> with ILLEGAL_TRAP_EN, state=13 and illegal_op held 1; without it, a one-cycle illegal_op pulse and return to FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS main control FSM.
//   The package holds:
//     - the state encoding
//     - the opcode constants
//     - the datapath select codes
//     - the control bundle produced by the decoder
//     - a dispatch helper used by both the FSM and the decoder
//   Optional feature macro: ILLEGAL_TRAP_EN. It is not used here; it is
//   consumed by mc_ctrl_fsm and mc_ctrl_decode.
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  localparam int NUM_STATES = 14;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE   = 6'b000000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_J       = 6'b000010;
  // All I-type ALU immediates share the top three opcode bits.
  localparam logic [2:0] OP_IMM_PFX = 3'b001;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_IMM   = 3'b011;
  localparam logic [2:0] ALUOP_BGTZ  = 3'b100;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] BR_EQ  = 2'b00;
  localparam logic [1:0] BR_NE  = 2'b01;
  localparam logic [1:0] BR_GTZ = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] branch_type;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  // DECODE dispatch target for an opcode.
  // S_TRAP marks an opcode with no legal destination. The FSM then
  // decides, based on ILLEGAL_TRAP_EN, whether TRAP is really entered.
  function automatic state_t dispatch_state(input logic [5:0] op);
    state_t target;
    target = S_TRAP;
    if (op == OP_RTYPE)                          target = S_EXEC;
    else if (op == OP_LW || op == OP_SW)         target = S_MEMADR;
    else if (op == OP_BEQ || op == OP_BNE ||
             op == OP_BGTZ)                      target = S_BRANCH;
    else if (op == OP_J)                         target = S_JUMP;
    else if (op[5:3] == OP_IMM_PFX)              target = S_IMMEX;
    return target;
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    return dispatch_state(op) != S_TRAP;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mc_ctrl_decode
//   Purely combinational map from the FSM state, the IR opcode and
//   mem_ready to the full control bundle.
//   Ports:
//     i_state     - current FSM state
//     i_opcode    - IR opcode; selects the branch flavour and the illegal
//                   flag
//     i_mem_ready - qualifies the FETCH strobes ir_write and pc_write
//     o_ctrl      - all control outputs
//   Optional feature macro: ILLEGAL_TRAP_EN (drives illegal_op in TRAP).
// ---------------------------------------------------------------------------
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  state_t           i_state,
  input  logic [OPW-1:0]   i_opcode,
  input  logic             i_mem_ready,
  output ctrl_t            o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        // IR and PC load only on the cycle the instruction word arrives.
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut during DECODE.
        o_ctrl.alu_src_b  = SRCB_IMMSH;
        o_ctrl.illegal_op = !is_legal_op(i_opcode);
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_IMMEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_IMM;
      end
      S_IMMWB: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_RT;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        // BRANCH is reached only for beq/bne/bgtz, so beq is the fallback.
        if (i_opcode == OP_BGTZ) begin
          o_ctrl.alu_op      = ALUOP_BGTZ;
          o_ctrl.branch_type = BR_GTZ;
        end else if (i_opcode == OP_BNE) begin
          o_ctrl.alu_op      = ALUOP_SUB;
          o_ctrl.branch_type = BR_NE;
        end else begin
          o_ctrl.alu_op      = ALUOP_SUB;
          o_ctrl.branch_type = BR_EQ;
        end
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        o_ctrl.illegal_op = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
//   Multi-cycle main control FSM for the MIPS core. It sequences:
//     fetch -> decode -> execute / memory -> writeback
//   It drives all datapath mux selects, the write strobes and the ALU
//   operation class.
//   Ports:
//     clk, rst_n     - rising-edge clock; asynchronous active-low reset
//     opcode         - IR opcode, valid from DECODE onward
//     mem_ready      - memory completes the current access this cycle
//     pc_write, pc_write_cond, branch_type, pc_source - PC update control
//     i_or_d, mem_read, mem_write, ir_write            - memory port control
//     mem_to_reg, reg_dst, reg_write                   - register file control
//     alu_src_a, alu_src_b, alu_op                     - ALU control
//     illegal_op     - illegal opcode flag
//     state          - current state, for debug
//   Optional feature macro: ILLEGAL_TRAP_EN.
//     Defined:   an illegal opcode parks the FSM in TRAP until reset.
//     Undefined: an illegal opcode is treated as a nop and the FSM
//                returns to FETCH.
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       branch_type,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_source,
  output logic [2:0]       alu_op,
  output logic             illegal_op,
  output logic [STW-1:0]   state
);

  state_t r_state;
  state_t w_next;
  state_t w_dispatch;
  ctrl_t  w_ctrl;

  assign w_dispatch = dispatch_state(opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:  w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        w_next = w_dispatch;
`else
        w_next = (w_dispatch == S_TRAP) ? S_FETCH : w_dispatch;
`endif
      end
      S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_EXEC:   w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_IMMEX:  w_next = S_IMMWB;
      S_IMMWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`else
      // TRAP cannot be reached in this build; recover to FETCH regardless.
      S_TRAP:   w_next = S_FETCH;
`endif
      default:  w_next = S_RESET;
    endcase
  end

  mc_ctrl_decode #(
    .OPW (OPW)
  ) u_decode (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign branch_type   = w_ctrl.branch_type;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign pc_source     = w_ctrl.pc_source;
  assign alu_op        = w_ctrl.alu_op;
  assign illegal_op    = w_ctrl.illegal_op;
  assign state         = STW'(r_state);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
//   Scoreboard bench for mc_ctrl_fsm.
//   Each stimulus cycle pushes the hand-derived state and control vector
//   for that cycle. A monitor pops and compares on every falling edge.
//   Expectations follow ILLEGAL_TRAP_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  localparam int OPW = 6;
  localparam int STW = 4;

  localparam logic [3:0] ST_RESET  = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_MEMADR = 4'd3;
  localparam logic [3:0] ST_MEMRD  = 4'd4;
  localparam logic [3:0] ST_MEMWB  = 4'd5;
  localparam logic [3:0] ST_MEMWR  = 4'd6;
  localparam logic [3:0] ST_EXEC   = 4'd7;
  localparam logic [3:0] ST_ALUWB  = 4'd8;
  localparam logic [3:0] ST_IMMEX  = 4'd9;
  localparam logic [3:0] ST_IMMWB  = 4'd10;
  localparam logic [3:0] ST_BRANCH = 4'd11;
  localparam logic [3:0] ST_JUMP   = 4'd12;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] ST_TRAP   = 4'd13;
`endif

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_BNE  = 6'b000101;
  localparam logic [5:0] OPC_BGTZ = 6'b000111;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_BAD  = 6'b111111;

  // Control vector bit layout, MSB to LSB:
  //   pc_write, pc_write_cond, branch_type[2], i_or_d, mem_read,
  //   mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
  //   alu_src_b[2], pc_source[2], alu_op[3], illegal_op
  localparam logic [19:0] E_ZERO       = 20'b0_0_00_0_0_0_0_0_0_0_0_00_00_000_0;
  localparam logic [19:0] E_FETCH_RDY  = 20'b1_0_00_0_1_0_1_0_0_0_0_01_00_000_0;
  localparam logic [19:0] E_FETCH_WAIT = 20'b0_0_00_0_1_0_0_0_0_0_0_01_00_000_0;
  localparam logic [19:0] E_DECODE     = 20'b0_0_00_0_0_0_0_0_0_0_0_11_00_000_0;
  localparam logic [19:0] E_DECODE_ILL = 20'b0_0_00_0_0_0_0_0_0_0_0_11_00_000_1;
  localparam logic [19:0] E_MEMADR     = 20'b0_0_00_0_0_0_0_0_0_0_1_10_00_000_0;
  localparam logic [19:0] E_MEMRD      = 20'b0_0_00_1_1_0_0_0_0_0_0_00_00_000_0;
  localparam logic [19:0] E_MEMWB      = 20'b0_0_00_0_0_0_0_1_0_1_0_00_00_000_0;
  localparam logic [19:0] E_MEMWR      = 20'b0_0_00_1_0_1_0_0_0_0_0_00_00_000_0;
  localparam logic [19:0] E_EXEC       = 20'b0_0_00_0_0_0_0_0_0_0_1_00_00_010_0;
  localparam logic [19:0] E_ALUWB      = 20'b0_0_00_0_0_0_0_0_1_1_0_00_00_000_0;
  localparam logic [19:0] E_IMMEX      = 20'b0_0_00_0_0_0_0_0_0_0_1_10_00_011_0;
  localparam logic [19:0] E_IMMWB      = 20'b0_0_00_0_0_0_0_0_0_1_0_00_00_000_0;
  localparam logic [19:0] E_BEQ        = 20'b0_1_00_0_0_0_0_0_0_0_1_00_01_001_0;
  localparam logic [19:0] E_BNE        = 20'b0_1_01_0_0_0_0_0_0_0_1_00_01_001_0;
  localparam logic [19:0] E_BGTZ       = 20'b0_1_10_0_0_0_0_0_0_0_1_00_01_100_0;
  localparam logic [19:0] E_JUMP       = 20'b1_0_00_0_0_0_0_0_0_0_0_00_10_000_0;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [19:0] E_TRAP       = 20'b0_0_00_0_0_0_0_0_0_0_0_00_00_000_1;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [OPW-1:0]   opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       branch_type;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       pc_source;
  logic [2:0]       alu_op;
  logic             illegal_op;
  logic [STW-1:0]   state;
  logic [19:0]      actCtl;

  typedef struct packed {
    logic [3:0]  st;
    logic [19:0] ctl;
  } exp_t;

  exp_t expQ[$];
  int   errCount   = 0;
  int   checkCount = 0;
  int   recIdx     = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(
    .OPW (OPW),
    .STW (STW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_type   (branch_type),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_source     (pc_source),
    .alu_op        (alu_op),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  assign actCtl = {pc_write, pc_write_cond, branch_type, i_or_d, mem_read,
                   mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                   alu_src_a, alu_src_b, pc_source, alu_op, illegal_op};

  // Drive one cycle's inputs shortly after the rising edge and queue
  // what the DUT must show for the remainder of that cycle.
  task automatic applyStimulus(input logic rstN, input logic [5:0] op,
                               input logic rdy, input logic [3:0] expSt,
                               input logic [19:0] expCtl);
    exp_t e;
    rst_n     = rstN;
    opcode    = op;
    mem_ready = rdy;
    e.st      = expSt;
    e.ctl     = expCtl;
    expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    checkCount++;
    if ({state, actCtl} !== {e.st, e.ctl}) begin
      errCount++;
      $display("[TB] FAIL rec%0d: got state=%0d ctl=%b, want state=%0d ctl=%b",
               recIdx, state, actCtl, e.st, e.ctl);
    end
    recIdx++;
  endtask

  // Monitor: compare mid-cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    rst_n     = 1'b0;
    opcode    = OPC_R;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, then release: state stays 0 until the next edge.
    applyStimulus(1'b0, OPC_R, 1'b0, ST_RESET, E_ZERO);
    applyStimulus(1'b1, OPC_R, 1'b0, ST_RESET, E_ZERO);

    // R-type, memory always ready.
    applyStimulus(1'b1, OPC_R, 1'b1, ST_FETCH,  E_FETCH_RDY);
    applyStimulus(1'b1, OPC_R, 1'b1, ST_DECODE, E_DECODE);
    applyStimulus(1'b1, OPC_R, 1'b1, ST_EXEC,   E_EXEC);
    applyStimulus(1'b1, OPC_R, 1'b1, ST_ALUWB,  E_ALUWB);

    // lw with two wait cycles in MEMRD. mem_ready is ignored elsewhere.
    applyStimulus(1'b1, OPC_LW, 1'b1, ST_FETCH,  E_FETCH_RDY);
    applyStimulus(1'b1, OPC_LW, 1'b0, ST_DECODE, E_DECODE);
    applyStimulus(1'b1, OPC_LW, 1'b0, ST_MEMADR, E_MEMADR);
    applyStimulus(1'b1, OPC_LW, 1'b0, ST_MEMRD,  E_MEMRD);
    applyStimulus(1'b1, OPC_LW, 1'b0, ST_MEMRD,  E_MEMRD);
    applyStimulus(1'b1, OPC_LW, 1'b1, ST_MEMRD,  E_MEMRD);
    applyStimulus(1'b1, OPC_LW, 1'b0, ST_MEMWB,  E_MEMWB);

    // sw with one fetch wait cycle.
    applyStimulus(1'b1, OPC_SW, 1'b0, ST_FETCH,  E_FETCH_WAIT);
    applyStimulus(1'b1, OPC_SW, 1'b1, ST_FETCH,  E_FETCH_RDY);
    applyStimulus(1'b1, OPC_SW, 1'b1, ST_DECODE, E_DECODE);
    applyStimulus(1'b1, OPC_SW, 1'b1, ST_MEMADR, E_MEMADR);
    applyStimulus(1'b1, OPC_SW, 1'b1, ST_MEMWR,  E_MEMWR);

    // Branches: bgtz, bne, beq.
    applyStimulus(1'b1, OPC_BGTZ, 1'b1, ST_FETCH,  E_FETCH_RDY);
    applyStimulus(1'b1, OPC_BGTZ, 1'b1, ST_DECODE, E_DECODE);
    applyStimulus(1'b1, OPC_BGTZ, 1'b1, ST_BRANCH, E_BGTZ);
    applyStimulus(1'b1, OPC_BNE,  1'b1, ST_FETCH,  E_FETCH_RDY);
    applyStimulus(1'b1, OPC_BNE,  1'b1, ST_DECODE, E_DECODE);
    applyStimulus(1'b1, OPC_BNE,  1'b1, ST_BRANCH, E_BNE);
    applyStimulus(1'b1, OPC_BEQ,  1'b1, ST_FETCH,  E_FETCH_RDY);
    applyStimulus(1'b1, OPC_BEQ,  1'b1, ST_DECODE, E_DECODE);
    applyStimulus(1'b1, OPC_BEQ,  1'b1, ST_BRANCH, E_BEQ);

    // Jump.
    applyStimulus(1'b1, OPC_J, 1'b1, ST_FETCH,  E_FETCH_RDY);
    applyStimulus(1'b1, OPC_J, 1'b1, ST_DECODE, E_DECODE);
    applyStimulus(1'b1, OPC_J, 1'b1, ST_JUMP,   E_JUMP);

    // addi.
    applyStimulus(1'b1, OPC_ADDI, 1'b1, ST_FETCH,  E_FETCH_RDY);
    applyStimulus(1'b1, OPC_ADDI, 1'b1, ST_DECODE, E_DECODE);
    applyStimulus(1'b1, OPC_ADDI, 1'b1, ST_IMMEX,  E_IMMEX);
    applyStimulus(1'b1, OPC_ADDI, 1'b1, ST_IMMWB,  E_IMMWB);

    // Illegal opcode.
    applyStimulus(1'b1, OPC_BAD, 1'b1, ST_FETCH,  E_FETCH_RDY);
    applyStimulus(1'b1, OPC_BAD, 1'b1, ST_DECODE, E_DECODE_ILL);
`ifdef ILLEGAL_TRAP_EN
    applyStimulus(1'b1, OPC_BAD, 1'b1, ST_TRAP,  E_TRAP);
    applyStimulus(1'b1, OPC_R,   1'b0, ST_TRAP,  E_TRAP);
    applyStimulus(1'b0, OPC_R,   1'b0, ST_RESET, E_ZERO);
    applyStimulus(1'b1, OPC_R,   1'b0, ST_RESET, E_ZERO);
`endif

    // Asynchronous reset in the middle of a MEMRD wait.
    applyStimulus(1'b1, OPC_LW, 1'b1, ST_FETCH,  E_FETCH_RDY);
    applyStimulus(1'b1, OPC_LW, 1'b1, ST_DECODE, E_DECODE);
    applyStimulus(1'b1, OPC_LW, 1'b1, ST_MEMADR, E_MEMADR);
    applyStimulus(1'b1, OPC_LW, 1'b0, ST_MEMRD,  E_MEMRD);
    applyStimulus(1'b0, OPC_LW, 1'b1, ST_RESET,  E_ZERO);
    applyStimulus(1'b0, OPC_LW, 1'b1, ST_RESET,  E_ZERO);
    applyStimulus(1'b1, OPC_LW, 1'b0, ST_RESET,  E_ZERO);
    applyStimulus(1'b1, OPC_LW, 1'b0, ST_FETCH,  E_FETCH_WAIT);

    // Every queued expectation must have been consumed by the monitor.
    @(negedge clk);
    #1;
    checkCount++;
    if (expQ.size() != 0) begin
      errCount++;
      $display("[TB] FAIL drain: got %0d pending records, want 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
